io_port_responder: RTL and testbench

IO_PORT_RESPONDER -- requirements
Module: io_port_responder

---
 rtl/io_port_responder.sv | 98 +++++++++
 tb/tb_io_port_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/io_port_responder.sv
// CPU-mapped I/O port block: two registered outputs, two synchronized inputs and an
// optional reload timer with level interrupt (enabled by defining IO_PORT_TIMER_EN).
module io_port_responder #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        io_addr,
  input  logic              io_we,
  input  logic              io_re,
  input  logic [DATA_W-1:0] io_wdata,
  output logic [DATA_W-1:0] io_rdata,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic              irq
);

  logic [DATA_W-1:0] in0_s1, in0_s2, in1_s1, in1_s2;
  logic [DATA_W-1:0] cnt_rd, ctrl_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out0   <= '0;
      out1   <= '0;
      in0_s1 <= '0;
      in0_s2 <= '0;
      in1_s1 <= '0;
      in1_s2 <= '0;
    end else begin
      in0_s1 <= in0;
      in0_s2 <= in0_s1;
      in1_s1 <= in1;
      in1_s2 <= in1_s1;
      if (io_we && io_addr == 2'd0) out0 <= io_wdata;
      if (io_we && io_addr == 2'd1) out1 <= io_wdata;
    end
  end

`ifdef IO_PORT_TIMER_EN
  logic [DATA_W-1:0] reload, counter;
  logic              tmr_en, irq_en, pending;
  logic              wr_reload, wr_ctrl, expire;

  assign wr_reload = io_we && (io_addr == 2'd2);
  assign wr_ctrl   = io_we && (io_addr == 2'd3);
  assign expire    = tmr_en && (counter == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload  <= '0;
      counter <= '0;
      tmr_en  <= 1'b0;
      irq_en  <= 1'b0;
      pending <= 1'b0;
    end else begin
      // CPU reload write overrides the countdown in the same cycle
      if (wr_reload) begin
        reload  <= io_wdata;
        counter <= io_wdata;
      end else if (tmr_en) begin
        counter <= expire ? reload : counter - DATA_W'(1);
      end
      if (wr_ctrl) begin
        tmr_en <= io_wdata[0];
        irq_en <= io_wdata[1];
      end
      // expiry wins over a simultaneous write-1-to-clear
      if (expire)
        pending <= 1'b1;
      else if (wr_ctrl && io_wdata[7])
        pending <= 1'b0;
    end
  end

  assign cnt_rd  = counter;
  assign ctrl_rd = {{(DATA_W-3){1'b0}}, pending, irq_en, tmr_en};
  assign irq     = pending & irq_en;
`else
  assign cnt_rd  = '0;
  assign ctrl_rd = '0;
  assign irq     = 1'b0;
`endif

  always_comb begin
    io_rdata = '0;
    if (io_re) begin
      case (io_addr)
        2'd0:    io_rdata = in0_s2;
        2'd1:    io_rdata = in1_s2;
        2'd2:    io_rdata = cnt_rd;
        default: io_rdata = ctrl_rd;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: vector table for port/sync behaviour plus
// hand sequences for reset and the timer (or its absence without IO_PORT_TIMER_EN).
module tb_io_port_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] io_addr;
  logic       io_we, io_re;
  logic [7:0] io_wdata, io_rdata, in0, in1, out0, out1;
  logic       irq;

  int checks = 0;
  int errors = 0;

  io_port_responder #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_we(io_we), .io_re(io_re),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .in0(in0), .in1(in1),
    .out0(out0), .out1(out1), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       re;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] exp_rd;
    logic [7:0] exp_o0;
    logic [7:0] exp_o1;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] addr, input logic [7:0] wd, input logic re);
    io_we = we; io_addr = addr; io_wdata = wd; io_re = re;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    in0 = 8'h00; in1 = 8'h00;

    vecs[0]  = '{1'b0, 2'd0, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 2'd0, 8'hA5, 1'b0, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 2'd1, 8'h3C, 1'b1, 8'h5A, 8'h00, 8'h00, 8'hA5, 8'h00};
    vecs[3]  = '{1'b0, 2'd0, 8'h00, 1'b1, 8'h5A, 8'h00, 8'h5A, 8'hA5, 8'h3C};
    vecs[4]  = '{1'b0, 2'd1, 8'hFF, 1'b1, 8'h5A, 8'hC3, 8'h00, 8'hA5, 8'h3C};
    vecs[5]  = '{1'b0, 2'd1, 8'h00, 1'b1, 8'h5A, 8'hC3, 8'h00, 8'hA5, 8'h3C};
    vecs[6]  = '{1'b0, 2'd1, 8'h00, 1'b1, 8'h5A, 8'hC3, 8'hC3, 8'hA5, 8'h3C};
    vecs[7]  = '{1'b0, 2'd2, 8'h00, 1'b1, 8'h5A, 8'hC3, 8'h00, 8'hA5, 8'h3C};
    vecs[8]  = '{1'b0, 2'd3, 8'h00, 1'b1, 8'h5A, 8'hC3, 8'h00, 8'hA5, 8'h3C};
    vecs[9]  = '{1'b1, 2'd0, 8'h00, 1'b0, 8'h5A, 8'hC3, 8'h00, 8'hA5, 8'h3C};
    vecs[10] = '{1'b0, 2'd0, 8'h00, 1'b1, 8'h5A, 8'hC3, 8'h5A, 8'h00, 8'h3C};

    // reset state, all addresses read as zero
    #2;
    for (int a = 0; a < 4; a++) begin
      io_addr = 2'(a);
      #1;
      chk("reset_rdata", io_rdata, 8'h00);
    end
    chk("reset_out0", out0, 8'h00);
    chk("reset_out1", out1, 8'h00);
    chk("reset_irq", {7'b0, irq}, 8'h00);
    step();
    @(negedge clk);
    reset = 1'b0;
    step();

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].re);
      in0 = vecs[i].in0;
      in1 = vecs[i].in1;
      #1;
      chk($sformatf("vec%0d_rdata", i), io_rdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_out0", i), out0, vecs[i].exp_o0);
      chk($sformatf("vec%0d_out1", i), out1, vecs[i].exp_o1);
      chk($sformatf("vec%0d_irq", i), {7'b0, irq}, 8'h00);
      step();
    end

    // synchronizer latency: new value visible after exactly two edges
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    in0 = 8'h11;
    step();
    chk("sync_edge1", io_rdata, 8'h5A);
    step();
    chk("sync_edge2", io_rdata, 8'h11);

    // asynchronous reset between edges clears outputs and sync flops
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_out1", out1, 8'h00);
    chk("async_rst_rdata", io_rdata, 8'h00);
    #1;
    reset = 1'b0;
    in0 = 8'h00;
    step();

`ifdef IO_PORT_TIMER_EN
    // reload=3, enable timer+irq: expiry every 4 edges, cleared between
    drive(1'b1, 2'd2, 8'd3, 1'b0);
    step();
    drive(1'b1, 2'd3, 8'h03, 1'b0);
    step();
    for (int k = 1; k <= 12; k++) begin
      if (k % 4 == 1 && k > 1) drive(1'b1, 2'd3, 8'h83, 1'b0);
      else drive(1'b0, 2'd3, 8'h00, 1'b1);
      step();
      chk($sformatf("period_irq_k%0d", k), {7'b0, irq}, (k % 4 == 0) ? 8'h01 : 8'h00);
      if (k == 4) chk("ctrl_after_expiry", io_rdata, 8'h07);
    end

    // set wins over clear when reload=0
    drive(1'b1, 2'd2, 8'd0, 1'b0);
    step();
    drive(1'b1, 2'd3, 8'h83, 1'b1);
    step();
    chk("set_wins_irq", {7'b0, irq}, 8'h01);
    chk("set_wins_ctrl", io_rdata, 8'h07);
    // reload=5: clear takes effect away from expiry
    drive(1'b1, 2'd2, 8'd5, 1'b0);
    step();
    drive(1'b1, 2'd3, 8'h83, 1'b1);
    step();
    chk("clear_irq", {7'b0, irq}, 8'h00);
    chk("clear_ctrl", io_rdata, 8'h03);

    // reset mid-countdown
    drive(1'b0, 2'd2, 8'h00, 1'b1);
    step();
    step();
    chk("cnt_before_rst", io_rdata, 8'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_cnt", io_rdata, 8'h00);
    io_addr = 2'd3;
    #1;
    chk("rst_ctrl", io_rdata, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    reset = 1'b0;
    io_addr = 2'd2;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("post_rst_cnt", io_rdata, 8'h00);
      chk("post_rst_irq", {7'b0, irq}, 8'h00);
    end
`else
    // timer absent: control/reload writes have no effect
    drive(1'b1, 2'd3, 8'h03, 1'b0);
    step();
    drive(1'b1, 2'd2, 8'h01, 1'b0);
    step();
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, (k % 2 == 0) ? 2'd2 : 2'd3, 8'h00, 1'b1);
      step();
      chk($sformatf("notimer_rd_k%0d", k), io_rdata, 8'h00);
      chk($sformatf("notimer_irq_k%0d", k), {7'b0, irq}, 8'h00);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
